// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and widths for the memory port arbiter
//
// Contents:
//   REG_BUS_W   : default data width of the core's register bus
//   INST_ADDR_W : default instruction address width
//   STARVE_W    : width of the IF starvation counter (holds up to 15)
//   owner_e     : which requester the SRAM response returning next cycle belongs to
package mem_port_arbiter_pkg;

    localparam int REG_BUS_W   = 32;
    localparam int INST_ADDR_W = 32;
    localparam int STARVE_W    = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_resp_hold.sv
// rtl/mem_port_arbiter_resp_hold.sv - per-requester read response hold register
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   resp_due   : the SRAM output this cycle belongs to this requester
//   sram_rdata : raw SRAM read data
//   rvalid     : response valid for this requester
//   rdata      : live SRAM data in the response cycle, last captured value otherwise
module mem_port_arbiter_resp_hold
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              resp_due,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (resp_due) begin
            hold_q <= sram_rdata;
        end
    end

    // Reset discards a response that is already on the SRAM output.
    assign rvalid = resp_due & ~rst;
    assign rdata  = rst ? '0 : (resp_due ? sram_rdata : hold_q);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port SRAM between instruction fetch and data access
//
// Optional feature macro: ARB_PERF_CNT_EN (builds the two performance counters;
// without it both perf ports are tied to 0).
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   if_req/if_addr              : IF read request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata   : IF grant, response valid (next cycle), held read data
//   mem_req/mem_wen/mem_addr/mem_wdata : MEM request (wen == 0 means read), held until mem_gnt
//   mem_gnt/mem_rvalid/mem_rdata: MEM grant, response valid (reads only), held read data
//   stallreq_if/stallreq_mem    : requester present but not granted
//   sram_en/sram_wen/sram_addr/sram_wdata/sram_rdata : SRAM port, 1-cycle read latency
//   perf_conflict_cnt           : cycles with both requests present
//   perf_if_stall_cnt           : cycles with IF denied
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = INST_ADDR_W,
    parameter int DATA_W     = REG_BUS_W,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic [3:0]        mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stallreq_if,
    output logic              stallreq_mem,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [31:0]       perf_conflict_cnt,
    output logic [31:0]       perf_if_stall_cnt
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    owner_e              owner_q, owner_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                starve_hit;

    assign starve_hit = (starve_q == STARVE_LIM);

    // Grants: MEM holds the older instruction so it wins, unless IF has been
    // starved long enough. Nothing is granted while reset is held.
    always_comb begin
        if_gnt  = 1'b0;
        mem_gnt = 1'b0;
        if (!rst) begin
            if (if_req && (!mem_req || starve_hit)) begin
                if_gnt = 1'b1;
            end else if (mem_req) begin
                mem_gnt = 1'b1;
            end
        end
    end

    assign stallreq_if  = ~rst & if_req  & ~if_gnt;
    assign stallreq_mem = ~rst & mem_req & ~mem_gnt;

    always_comb begin
        sram_en    = if_gnt | mem_gnt;
        sram_wen   = 4'b0000;
        sram_addr  = '0;
        sram_wdata = '0;
        if (if_gnt) begin
            sram_addr = if_addr;
        end else if (mem_gnt) begin
            sram_addr  = mem_addr;
            sram_wen   = mem_wen;
            sram_wdata = mem_wdata;
        end
    end

    // Response owner and starvation counter: state register plus next-state logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= OWN_NONE;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        owner_d  = OWN_NONE;
        starve_d = starve_q;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (mem_gnt && (mem_wen == 4'b0000)) begin
            owner_d = OWN_MEM;
        end
        // Writes fall through to OWN_NONE: they produce no response.
        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (mem_gnt && !starve_hit) begin
            starve_d = starve_q + 1'b1;
        end
    end

    mem_port_arbiter_resp_hold #(.DATA_W(DATA_W)) u_if_hold (
        .clk        (clk),
        .rst        (rst),
        .resp_due   (owner_q == OWN_IF),
        .sram_rdata (sram_rdata),
        .rvalid     (if_rvalid),
        .rdata      (if_rdata)
    );

    mem_port_arbiter_resp_hold #(.DATA_W(DATA_W)) u_mem_hold (
        .clk        (clk),
        .rst        (rst),
        .resp_due   (owner_q == OWN_MEM),
        .sram_rdata (sram_rdata),
        .rvalid     (mem_rvalid),
        .rdata      (mem_rdata)
    );

`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_q;
    logic [31:0] if_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= '0;
            if_stall_q <= '0;
        end else begin
            if (if_req && mem_req) begin
                conflict_q <= conflict_q + 32'd1;
            end
            if (stallreq_if) begin
                if_stall_q <= if_stall_q + 32'd1;
            end
        end
    end

    assign perf_conflict_cnt = conflict_q;
    assign perf_if_stall_cnt = if_stall_q;
`else
    assign perf_conflict_cnt = 32'd0;
    assign perf_if_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int SMAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        mem_req = 1'b0;
    logic [3:0]  mem_wen = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stallreq_if, stallreq_mem;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata = '0;
    logic [31:0] perf_conflict_cnt, perf_if_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    bit          sram_auto = 1'b0;
    logic [31:0] sram_manual = '0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .perf_conflict_cnt(perf_conflict_cnt), .perf_if_stall_cnt(perf_if_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sram_f(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // SRAM model: data one cycle after an enabled read, garbage otherwise.
    always @(posedge clk) begin
        if (sram_auto)
            sram_rdata <= (sram_en && sram_wen == 4'b0000) ? sram_f(sram_addr) : $urandom;
        else
            sram_rdata <= sram_manual;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; if_req = 1'b0; mem_req = 1'b0;
        tick; tick;
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (sram_en !== 1'b0) begin n_fail++; $display("FAIL reset_sram_en: got %b want 0", sram_en); end
        n_tests++; if ({if_gnt, mem_gnt, if_rvalid, mem_rvalid} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {if_gnt, mem_gnt, if_rvalid, mem_rvalid}); end
        n_tests++; if (if_rdata !== 32'd0 || mem_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 0 0", if_rdata, mem_rdata); end
        n_tests++; if (perf_conflict_cnt !== 32'd0 || perf_if_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_perf: got %0d %0d want 0 0", perf_conflict_cnt, perf_if_stall_cnt); end
        tick;
    endtask

    task automatic test_if_only;
        sram_auto = 1'b0;
        if_req = 1'b1; if_addr = 32'h1FC0_0000; sram_manual = 32'h2408_0001;
        @(negedge clk);
        n_tests++; if (if_gnt !== 1'b1 || mem_gnt !== 1'b0) begin n_fail++; $display("FAIL if_only_gnt: got %b%b want 10", if_gnt, mem_gnt); end
        n_tests++; if (sram_en !== 1'b1 || sram_addr !== 32'h1FC0_0000 || sram_wen !== 4'b0) begin n_fail++; $display("FAIL if_only_sram: got en=%b addr=%h wen=%b", sram_en, sram_addr, sram_wen); end
        n_tests++; if (stallreq_if !== 1'b0) begin n_fail++; $display("FAIL if_only_stall: got %b want 0", stallreq_if); end
        tick;
        if_req = 1'b0; sram_manual = 32'h0BAD_0BAD;
        @(negedge clk);
        n_tests++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h2408_0001) begin n_fail++; $display("FAIL if_only_resp: got v=%b d=%h want 1 24080001", if_rvalid, if_rdata); end
        tick;
        @(negedge clk);
        n_tests++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h2408_0001) begin n_fail++; $display("FAIL if_only_hold: got v=%b d=%h want 0 24080001", if_rvalid, if_rdata); end
        tick;
    endtask

    task automatic test_conflict;
        if_req = 1'b1; if_addr = 32'h1FC0_0004;
        mem_req = 1'b1; mem_wen = 4'b0; mem_addr = 32'h0000_0100; sram_manual = 32'h1111_1111;
        @(negedge clk);
        n_tests++; if (mem_gnt !== 1'b1 || if_gnt !== 1'b0) begin n_fail++; $display("FAIL conflict_gnt: got if=%b mem=%b want 0 1", if_gnt, mem_gnt); end
        n_tests++; if (stallreq_if !== 1'b1 || sram_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL conflict_stall: got stall=%b addr=%h want 1 00000100", stallreq_if, sram_addr); end
        tick;
        mem_req = 1'b0; sram_manual = 32'h2222_2222;
        @(negedge clk);
        n_tests++; if (mem_rvalid !== 1'b1 || mem_rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL conflict_mem_resp: got v=%b d=%h want 1 11111111", mem_rvalid, mem_rdata); end
        n_tests++; if (if_gnt !== 1'b1 || sram_addr !== 32'h1FC0_0004) begin n_fail++; $display("FAIL conflict_if_after: got gnt=%b addr=%h want 1 1fc00004", if_gnt, sram_addr); end
        tick;
        if_req = 1'b0;
        @(negedge clk);
        n_tests++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h2222_2222 || mem_rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL conflict_if_resp: got v=%b if=%h mem=%h", if_rvalid, if_rdata, mem_rdata); end
        tick;
    endtask

    task automatic test_starve;
        for (int k = 0; k <= SMAX; k++) begin
            if_req = 1'b1; if_addr = 32'h1FC0_0010;
            mem_req = 1'b1; mem_wen = 4'b0; mem_addr = 32'h0000_0300 + 32'(4 * k);
            @(negedge clk);
            n_tests++; if (if_gnt !== (k == SMAX) || mem_gnt !== (k != SMAX)) begin n_fail++; $display("FAIL starve_gnt_%0d: got if=%b mem=%b", k, if_gnt, mem_gnt); end
            n_tests++; if (stallreq_mem !== (k == SMAX) || stallreq_if !== (k != SMAX)) begin n_fail++; $display("FAIL starve_stall_%0d: got if=%b mem=%b", k, stallreq_if, stallreq_mem); end
            tick;
        end
        if_req = 1'b0; mem_req = 1'b0;
        tick;
    endtask

    task automatic test_write;
        mem_req = 1'b1; mem_wen = 4'b0011; mem_addr = 32'h0000_0200; mem_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_tests++; if (mem_gnt !== 1'b1 || sram_en !== 1'b1 || sram_wen !== 4'b0011) begin n_fail++; $display("FAIL write_drive: got gnt=%b en=%b wen=%b", mem_gnt, sram_en, sram_wen); end
        n_tests++; if (sram_wdata !== 32'hDEAD_BEEF || sram_addr !== 32'h0000_0200) begin n_fail++; $display("FAIL write_data: got %h @%h want deadbeef @00000200", sram_wdata, sram_addr); end
        tick;
        mem_req = 1'b0; mem_wen = 4'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_tests++; if (mem_rvalid !== 1'b0) begin n_fail++; $display("FAIL write_no_rvalid_%0d: got %b want 0", k, mem_rvalid); end
            tick;
        end
    endtask

    task automatic test_reset_mid;
        if_req = 1'b1; if_addr = 32'h1FC0_0020; sram_manual = 32'h55AA_55AA;
        @(negedge clk);
        n_tests++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt: got %b want 1", if_gnt); end
        tick;
        rst = 1'b1; if_req = 1'b0;
        @(negedge clk);
        n_tests++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid_in_rst: got %b want 0", if_rvalid); end
        tick;
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if ({if_gnt, mem_gnt, if_rvalid, mem_rvalid, stallreq_if, stallreq_mem, sram_en} !== 7'b0) begin n_fail++; $display("FAIL rstmid_flags: got %b want 0", {if_gnt, mem_gnt, if_rvalid, mem_rvalid, stallreq_if, stallreq_mem, sram_en}); end
        n_tests++; if (if_rdata !== 32'd0 || mem_rdata !== 32'd0 || sram_addr !== 32'd0) begin n_fail++; $display("FAIL rstmid_data: got if=%h mem=%h addr=%h want 0", if_rdata, mem_rdata, sram_addr); end
        tick;
    endtask

    task automatic test_perf;
        logic [31:0] exp_conf, exp_stall;
        rst = 1'b1; tick; rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if_req = 1'b1; if_addr = 32'h1FC0_0040 + 32'(4 * k);
            mem_req = 1'b1; mem_wen = 4'b0; mem_addr = 32'h0000_0400 + 32'(4 * k);
            tick;
        end
        if_req = 1'b0; mem_req = 1'b0;
`ifdef ARB_PERF_CNT_EN
        exp_conf = 32'd5; exp_stall = 32'd4;
`else
        exp_conf = 32'd0; exp_stall = 32'd0;
`endif
        @(negedge clk);
        n_tests++; if (perf_conflict_cnt !== exp_conf) begin n_fail++; $display("FAIL perf_conflict: got %0d want %0d", perf_conflict_cnt, exp_conf); end
        n_tests++; if (perf_if_stall_cnt !== exp_stall) begin n_fail++; $display("FAIL perf_if_stall: got %0d want %0d", perf_if_stall_cnt, exp_stall); end
        tick;
    endtask

    task automatic test_random(int cycles);
        int          starve = 0;
        int          conf = 0, istall = 0;
        bit          if_pend = 0, mem_pend = 0;
        bit          e_if_gnt, e_mem_gnt;
        bit          prev_if_gnt = 1, prev_mem_gnt = 1;
        logic [31:0] if_pa = '0, mem_pa = '0, if_hold = '0, mem_hold = '0;
        logic [31:0] exp_conf, exp_stall;
        sram_auto = 1'b1;
        rst = 1'b1; if_req = 1'b0; mem_req = 1'b0;
        tick;
        rst = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (prev_if_gnt || !if_req) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = $urandom & 32'hFFFF_FFFC;
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end
            if (prev_mem_gnt || !mem_req) begin
                mem_req   = ($urandom_range(0, 2) != 0);
                mem_addr  = $urandom;
                mem_wen   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
                mem_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                mem_req = 1'b0;
            end
            e_if_gnt  = if_req && (!mem_req || starve == SMAX);
            e_mem_gnt = mem_req && !e_if_gnt;
            if (if_pend)  if_hold  = sram_f(if_pa);
            if (mem_pend) mem_hold = sram_f(mem_pa);
            @(negedge clk);
            n_tests++; if (if_gnt !== e_if_gnt || mem_gnt !== e_mem_gnt) begin n_fail++; $display("FAIL rand_gnt c%0d: got if=%b mem=%b want %b %b", c, if_gnt, mem_gnt, e_if_gnt, e_mem_gnt); end
            n_tests++; if (stallreq_if !== (if_req && !e_if_gnt) || stallreq_mem !== (mem_req && !e_mem_gnt)) begin n_fail++; $display("FAIL rand_stall c%0d: got %b %b", c, stallreq_if, stallreq_mem); end
            n_tests++; if (sram_en !== (e_if_gnt || e_mem_gnt)) begin n_fail++; $display("FAIL rand_en c%0d: got %b", c, sram_en); end
            if (e_if_gnt) begin
                n_tests++; if (sram_addr !== if_addr || sram_wen !== 4'b0 || sram_wdata !== 32'd0) begin n_fail++; $display("FAIL rand_if_drive c%0d: got addr=%h wen=%b wd=%h", c, sram_addr, sram_wen, sram_wdata); end
            end
            if (e_mem_gnt) begin
                n_tests++; if (sram_addr !== mem_addr || sram_wen !== mem_wen || sram_wdata !== mem_wdata) begin n_fail++; $display("FAIL rand_mem_drive c%0d: got addr=%h wen=%b wd=%h", c, sram_addr, sram_wen, sram_wdata); end
            end
            n_tests++; if (if_rvalid !== if_pend || if_rdata !== if_hold) begin n_fail++; $display("FAIL rand_if_resp c%0d: got v=%b d=%h want %b %h", c, if_rvalid, if_rdata, if_pend, if_hold); end
            n_tests++; if (mem_rvalid !== mem_pend || mem_rdata !== mem_hold) begin n_fail++; $display("FAIL rand_mem_resp c%0d: got v=%b d=%h want %b %h", c, mem_rvalid, mem_rdata, mem_pend, mem_hold); end
            if (if_req && mem_req) conf++;
            if (if_req && !e_if_gnt) istall++;
            if (!if_req || e_if_gnt) starve = 0;
            else if (e_mem_gnt && starve < SMAX) starve++;
            if_pend  = e_if_gnt;
            if_pa    = if_addr;
            mem_pend = e_mem_gnt && (mem_wen == 4'b0);
            mem_pa   = mem_addr;
            prev_if_gnt  = e_if_gnt;
            prev_mem_gnt = e_mem_gnt;
            tick;
        end
        if_req = 1'b0; mem_req = 1'b0;
`ifdef ARB_PERF_CNT_EN
        exp_conf = 32'(conf); exp_stall = 32'(istall);
`else
        exp_conf = 32'd0; exp_stall = 32'd0;
`endif
        @(negedge clk);
        n_tests++; if (perf_conflict_cnt !== exp_conf || perf_if_stall_cnt !== exp_stall) begin n_fail++; $display("FAIL rand_perf: got %0d %0d want %0d %0d", perf_conflict_cnt, perf_if_stall_cnt, exp_conf, exp_stall); end
        tick;
        sram_auto = 1'b0;
    endtask

    initial begin
        test_reset;
        test_if_only;
        test_conflict;
        test_starve;
        test_write;
        test_reset_mid;
        test_perf;
        test_random(2000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
